// File: rtl/io_sched_pkg.sv
// Shared types and sizes for the IO scheduler and its posted-write buffer.
package io_pkg;

  localparam int ADDR_W      = 23;
  localparam int DATA_W      = 16;
  localparam int WPOST_DEPTH = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RECOV = 2'd3
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              lds;
    logic              uds;
  } wpost_ent_t;

endpackage

// File: rtl/io_sched_if.sv
// CPU request port and IO bus slave port of the scheduler, one bundle.
interface io_sched_if;
  import io_pkg::*;

  logic              CPUREQ;
  logic              CPURW;
  logic              CPULDS;
  logic              CPUUDS;
  logic [ADDR_W-1:0] CPUA;
  logic [DATA_W-1:0] CPUD;
  logic              CPUACK;
  logic [DATA_W-1:0] CPUQ;

  logic              IOREQ;
  logic              IORW;
  logic              IOLDS;
  logic              IOUDS;
  logic [ADDR_W-1:0] IOA;
  logic [DATA_W-1:0] IOD;
  logic              IOACT;
  logic              IODONE;
  logic [DATA_W-1:0] IODIN;
  logic              BUSY;

  modport slave (
    input  CPUREQ, CPURW, CPULDS, CPUUDS, CPUA, CPUD,
    input  IOACT, IODONE, IODIN,
    output CPUACK, CPUQ,
    output IOREQ, IORW, IOLDS, IOUDS, IOA, IOD,
    output BUSY
  );

  modport master (
    output CPUREQ, CPURW, CPULDS, CPUUDS, CPUA, CPUD,
    output IOACT, IODONE, IODIN,
    input  CPUACK, CPUQ,
    input  IOREQ, IORW, IOLDS, IOUDS, IOA, IOD,
    input  BUSY
  );

endinterface

// File: rtl/io_wpost_fifo.sv
// Two-entry posted-write FIFO: 1-bit wrapping pointers plus an occupancy count.
module io_wpost_fifo
  import io_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic       pop_i,
  input  wpost_ent_t din_i,
  output wpost_ent_t dout_o,
  output logic [1:0] count_o,
  output logic       full_o
);

  wpost_ent_t mem_q [WPOST_DEPTH];
  logic       wp_q, wp_d;
  logic       rp_q, rp_d;
  logic [1:0] cnt_q, cnt_d;
  logic       do_push, do_pop;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign full_o  = (cnt_q == 2'(WPOST_DEPTH));
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & (cnt_q != 2'd0);

  always_comb begin
    wp_d  = wp_q ^ do_push;
    rp_d  = rp_q ^ do_pop;
    cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end

  assign dout_o  = mem_q[rp_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/io_sched.sv
// Schedules CPU IO requests onto the IO bus slave port, one cycle at a time.
// Define IOSCHED_WRPOST_EN to post writes through a 2-entry buffer.
module io_sched
  import io_pkg::*;
(
  input  logic      C16M,
  input  logic      nRES,
  io_sched_if.slave bus
);

`ifdef IOSCHED_WRPOST_EN
  localparam bit WRPOST = 1'b1;
`else
  localparam bit WRPOST = 1'b0;
`endif

  state_e            state_q, state_d;
  logic              ioreq_q, ioreq_d;
  logic              iorw_q, iorw_d;
  logic              iolds_q, iolds_d;
  logic              iouds_q, iouds_d;
  logic [ADDR_W-1:0] ioa_q, ioa_d;
  logic [DATA_W-1:0] iod_q, iod_d;
  logic [DATA_W-1:0] cpuq_q, cpuq_d;
  logic              cpuack_q, cpuack_d;
  logic              ackd_q, ackd_d;
  logic              src_cpu_q, src_cpu_d;

  logic              new_req;
  logic              direct_ok;
  logic              buf_nempty;

  assign new_req   = bus.CPUREQ & ~ackd_q;
  // With posting enabled only reads go direct, and only once the buffer has drained.
  assign direct_ok = WRPOST ? bus.CPURW : 1'b1;

`ifdef IOSCHED_WRPOST_EN
  logic [1:0] buf_cnt;
  logic       buf_full, buf_push, buf_pop;
  wpost_ent_t buf_head, buf_din;

  assign buf_din    = '{a: bus.CPUA, d: bus.CPUD, lds: bus.CPULDS, uds: bus.CPUUDS};
  assign buf_nempty = (buf_cnt != 2'd0);

  io_wpost_fifo u_wpost (
    .clk_i   (C16M),
    .rst_ni  (nRES),
    .push_i  (buf_push),
    .pop_i   (buf_pop),
    .din_i   (buf_din),
    .dout_o  (buf_head),
    .count_o (buf_cnt),
    .full_o  (buf_full)
  );
`else
  assign buf_nempty = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ioreq_d   = ioreq_q;
    iorw_d    = iorw_q;
    iolds_d   = iolds_q;
    iouds_d   = iouds_q;
    ioa_d     = ioa_q;
    iod_d     = iod_q;
    cpuq_d    = cpuq_q;
    src_cpu_d = src_cpu_q;
    cpuack_d  = 1'b0;
    ackd_d    = bus.CPUREQ ? ackd_q : 1'b0;
`ifdef IOSCHED_WRPOST_EN
    buf_push  = 1'b0;
    buf_pop   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (!bus.IOACT) begin
`ifdef IOSCHED_WRPOST_EN
          // Buffered writes drain first so a read never overtakes them.
          if (buf_nempty) begin
            state_d   = S_ISSUE;
            ioreq_d   = 1'b1;
            iorw_d    = 1'b0;
            ioa_d     = buf_head.a;
            iod_d     = buf_head.d;
            iolds_d   = buf_head.lds;
            iouds_d   = buf_head.uds;
            src_cpu_d = 1'b0;
          end else
`endif
          if (new_req && direct_ok) begin
            state_d   = S_ISSUE;
            ioreq_d   = 1'b1;
            iorw_d    = bus.CPURW;
            ioa_d     = bus.CPUA;
            iod_d     = bus.CPUD;
            iolds_d   = bus.CPULDS;
            iouds_d   = bus.CPUUDS;
            src_cpu_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (bus.IOACT) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.IODONE) begin
          state_d = S_RECOV;
          ioreq_d = 1'b0;
          iolds_d = 1'b0;
          iouds_d = 1'b0;
          if (src_cpu_q) begin
            cpuack_d = 1'b1;
            if (iorw_q) cpuq_d = bus.IODIN;
          end
`ifdef IOSCHED_WRPOST_EN
          // The entry stays resident until its IO cycle terminates.
          else buf_pop = 1'b1;
`endif
        end
      end
      S_RECOV: begin
        if (!bus.IOACT) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef IOSCHED_WRPOST_EN
    if (new_req && !bus.CPURW && !buf_full) begin
      buf_push = 1'b1;
      cpuack_d = 1'b1;
    end
`endif

    // ACKD rises with the pulse itself so the held request is never re-taken.
    if (cpuack_d) ackd_d = 1'b1;
  end

  always_ff @(posedge C16M) begin
    if (!nRES) begin
      state_q   <= S_IDLE;
      ioreq_q   <= 1'b0;
      iorw_q    <= 1'b1;
      iolds_q   <= 1'b0;
      iouds_q   <= 1'b0;
      ioa_q     <= '0;
      iod_q     <= '0;
      cpuq_q    <= '0;
      cpuack_q  <= 1'b0;
      ackd_q    <= 1'b0;
      src_cpu_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ioreq_q   <= ioreq_d;
      iorw_q    <= iorw_d;
      iolds_q   <= iolds_d;
      iouds_q   <= iouds_d;
      ioa_q     <= ioa_d;
      iod_q     <= iod_d;
      cpuq_q    <= cpuq_d;
      cpuack_q  <= cpuack_d;
      ackd_q    <= ackd_d;
      src_cpu_q <= src_cpu_d;
    end
  end

  assign bus.IOREQ  = ioreq_q;
  assign bus.IORW   = iorw_q;
  assign bus.IOLDS  = iolds_q;
  assign bus.IOUDS  = iouds_q;
  assign bus.IOA    = ioa_q;
  assign bus.IOD    = iod_q;
  assign bus.CPUACK = cpuack_q;
  assign bus.CPUQ   = cpuq_q;
  assign bus.BUSY   = (state_q != S_IDLE) | buf_nempty | new_req;

endmodule

// File: tb/tb_io_sched.sv
// Directed vector bench for io_sched with a behavioural IO bus master model.
module tb_io_sched;
  import io_pkg::*;

  typedef struct {
    logic        rw;
    logic [22:0] a;
    logic [15:0] d;
    logic        lds;
    logic        uds;
    logic [15:0] din;
    int          dly;
    int          hold;
    logic [15:0] q;
  } vec_t;

  typedef struct {
    logic        rw;
    logic [22:0] a;
    logic [15:0] d;
    logic        lds;
    logic        uds;
    int          cyc;
    int          rel;
  } io_rec_t;

  logic C16M;
  logic nRES;
  io_sched_if bus ();

  io_sched dut (.C16M(C16M), .nRES(nRES), .bus(bus));

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          ack_cnt = 0;
  int          done_cnt = 0;
  logic        slave_en = 1'b1;
  logic        slave_act = 1'b0;
  logic        ext_act = 1'b0;
  int          slave_dly = 2;
  logic [15:0] slave_din = 16'h0;
  io_rec_t     log_q[$];

  assign bus.IOACT = slave_act | ext_act;

  initial C16M = 1'b0;
  always #5 C16M = ~C16M;

  always @(posedge C16M) cyc <= cyc + 1;
  always @(negedge C16M) if (bus.CPUACK === 1'b1) ack_cnt <= ack_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(logic rw, logic [22:0] a, logic [15:0] d, logic lds, logic uds,
                              logic [15:0] din, int dly, int hold, logic [15:0] q);
    vec_t v;
    v.rw = rw; v.a = a; v.d = d; v.lds = lds; v.uds = uds;
    v.din = din; v.dly = dly; v.hold = hold; v.q = q;
    return v;
  endfunction

  task automatic cpu_start(input logic rw, input logic [22:0] a, input logic [15:0] d,
                           input logic lds, input logic uds);
    @(negedge C16M);
    bus.CPURW  = rw;
    bus.CPUA   = a;
    bus.CPUD   = d;
    bus.CPULDS = lds;
    bus.CPUUDS = uds;
    bus.CPUREQ = 1'b1;
  endtask

  task automatic wait_ack(input int lim, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge C16M);
      if (bus.CPUACK === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_ioreq(input int lim, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge C16M);
      if (bus.IOREQ === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int lim, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge C16M);
      if (bus.BUSY === 1'b0 && bus.IOACT === 1'b0 && bus.IOREQ === 1'b0) begin
        ok = 1'b1; break;
      end
    end
  endtask

  // IO bus master: answers each IOREQ with IOACT, IODONE after slave_dly cycles,
  // then keeps IOACT one more cycle so the recovery state is exercised.
  initial begin : io_slave
    io_rec_t r;
    bus.IODONE = 1'b0;
    bus.IODIN  = 16'h0;
    forever begin
      @(posedge C16M); #1;
      if (slave_en && bus.IOREQ === 1'b1) begin
        r.rw = bus.IORW; r.a = bus.IOA; r.d = bus.IOD;
        r.lds = bus.IOLDS; r.uds = bus.IOUDS; r.cyc = cyc; r.rel = 0;
        log_q.push_back(r);
        slave_act = 1'b1;
        repeat (slave_dly) @(posedge C16M);
        #1;
        bus.IODONE = 1'b1;
        bus.IODIN  = slave_din;
        done_cnt++;
        @(posedge C16M); #1;
        bus.IODONE = 1'b0;
        @(posedge C16M); #1;
        slave_act = 1'b0;
        log_q[log_q.size()-1].rel = cyc;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    vec_t tv[8];
    logic ok, bad;
    int   a0, n0, d0;

    tv[0] = mk(1'b1, 23'h7FFFFF, 16'h0000, 1'b1, 1'b1, 16'hA55A, 5, 0,  16'hA55A);
    tv[1] = mk(1'b0, 23'h000100, 16'h1234, 1'b1, 1'b1, 16'h0000, 2, 0,  16'hA55A);
    tv[2] = mk(1'b1, 23'h000100, 16'h0000, 1'b1, 1'b1, 16'h1234, 1, 10, 16'h1234);
    tv[3] = mk(1'b0, 23'h000000, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 3, 0,  16'h1234);
    tv[4] = mk(1'b1, 23'h2AAAAA, 16'h0000, 1'b0, 1'b1, 16'h0000, 1, 0,  16'h0000);
    tv[5] = mk(1'b0, 23'h555555, 16'h8001, 1'b0, 1'b1, 16'h0000, 4, 0,  16'h0000);
    tv[6] = mk(1'b1, 23'h000001, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 7, 0,  16'hFFFF);
    tv[7] = mk(1'b0, 23'h7FFFFF, 16'h0000, 1'b1, 1'b1, 16'h0000, 1, 10, 16'hFFFF);

    nRES = 1'b0;
    bus.CPUREQ = 1'b0; bus.CPURW = 1'b1; bus.CPULDS = 1'b0; bus.CPUUDS = 1'b0;
    bus.CPUA = '0; bus.CPUD = '0;
    repeat (3) @(negedge C16M);
    chk("rst_ioreq",  bus.IOREQ, 0);
    chk("rst_iorw",   bus.IORW, 1);
    chk("rst_be",     {bus.IOLDS, bus.IOUDS}, 0);
    chk("rst_cpuack", bus.CPUACK, 0);
    chk("rst_cpuq",   bus.CPUQ, 0);
    chk("rst_ioa",    bus.IOA, 0);
    chk("rst_iod",    bus.IOD, 0);
    chk("rst_busy",   bus.BUSY, 0);
    nRES = 1'b1;
    @(negedge C16M);

    for (int v = 0; v < 8; v++) begin
      a0 = ack_cnt; n0 = log_q.size();
      slave_din = tv[v].din; slave_dly = tv[v].dly;
      cpu_start(tv[v].rw, tv[v].a, tv[v].d, tv[v].lds, tv[v].uds);
      wait_ack(60, ok);
      chk("vec_ack_seen", ok, 1);
      chk("vec_cpuq", bus.CPUQ, tv[v].q);
      if (tv[v].rw) chk("vec_ioreq_low_at_ack", bus.IOREQ, 0);
      repeat (tv[v].hold) @(negedge C16M);
      bus.CPUREQ = 1'b0;
      wait_idle(80, ok);
      chk("vec_idle", ok, 1);
      chk("vec_ack_count", ack_cnt - a0, 1);
      chk("vec_io_count", log_q.size() - n0, 1);
      chk("vec_be_idle", {bus.IOLDS, bus.IOUDS}, 0);
      chk("vec_ioa_hold", bus.IOA, tv[v].a);
      if (log_q.size() > n0) begin
        chk("vec_io_rw", log_q[n0].rw, tv[v].rw);
        chk("vec_io_a",  log_q[n0].a,  tv[v].a);
        chk("vec_io_be", {log_q[n0].lds, log_q[n0].uds}, {tv[v].lds, tv[v].uds});
        if (!tv[v].rw) chk("vec_io_d", log_q[n0].d, tv[v].d);
      end
    end

    // Reset while an IO cycle is in WAIT: IOREQ drops, reissue only after IOACT=0.
    slave_en = 1'b0;
    cpu_start(1'b1, 23'h000ABC, 16'h0, 1'b1, 1'b1);
    wait_ioreq(4, ok);
    chk("rstmid_issue", ok, 1);
    ext_act = 1'b1;
    repeat (2) @(negedge C16M);
    nRES = 1'b0;
    @(negedge C16M);
    chk("rstmid_ioreq_drop", bus.IOREQ, 0);
    nRES = 1'b1;
    bad = 1'b0;
    repeat (3) begin
      @(negedge C16M);
      if (bus.IOREQ !== 1'b0) bad = 1'b1;
    end
    chk("rstmid_hold_while_ioact", bad, 0);
    ext_act = 1'b0;
    wait_ioreq(4, ok);
    chk("rstmid_reissue", ok, 1);
    chk("rstmid_reissue_a", bus.IOA, 23'h000ABC);
    slave_dly = 2; slave_din = 16'h0F0F; slave_en = 1'b1;
    wait_ack(40, ok);
    chk("rstmid_ack", ok, 1);
    chk("rstmid_cpuq", bus.CPUQ, 16'h0F0F);
    bus.CPUREQ = 1'b0;
    wait_idle(40, ok);
    chk("rstmid_idle", ok, 1);

`ifdef IOSCHED_WRPOST_EN
    // Three writes against a stalled bus: two post at once, the third waits for a slot.
    ext_act = 1'b1; slave_dly = 3; n0 = log_q.size();
    for (int k = 0; k < 3; k++) begin
      cpu_start(1'b0, 23'(16 + k), 16'(16'h1111 * (k + 1)), 1'b1, 1'b1);
      if (k < 2) begin
        wait_ack(2, ok);
        chk("post_ack_fast", ok, 1);
      end else begin
        wait_ack(6, ok);
        chk("post_ack_held_full", ok, 0);
        d0 = done_cnt;
        ext_act = 1'b0;
        wait_ack(60, ok);
        chk("post_ack_after_done", ok && (done_cnt > d0), 1);
      end
      bus.CPUREQ = 1'b0;
    end
    wait_idle(200, ok);
    chk("post_idle", ok, 1);
    chk("post_io_count", log_q.size() - n0, 3);
    if (log_q.size() == n0 + 3) begin
      for (int k = 0; k < 3; k++) begin
        chk("post_order_a", log_q[n0+k].a, 16 + k);
        chk("post_order_d", log_q[n0+k].d, 16'(16'h1111 * (k + 1)));
      end
    end

    // A read behind a posted write to the same address issues only after it retires.
    slave_dly = 4; slave_din = 16'h1234; n0 = log_q.size();
    cpu_start(1'b0, 23'h000100, 16'h1234, 1'b1, 1'b1);
    wait_ack(2, ok);
    chk("raw_wr_ack", ok, 1);
    bus.CPUREQ = 1'b0;
    cpu_start(1'b1, 23'h000100, 16'h0, 1'b1, 1'b1);
    wait_ack(80, ok);
    chk("raw_rd_ack", ok, 1);
    chk("raw_rd_q", bus.CPUQ, 16'h1234);
    bus.CPUREQ = 1'b0;
    wait_idle(80, ok);
    chk("raw_io_count", log_q.size() - n0, 2);
    if (log_q.size() == n0 + 2) begin
      chk("raw_order", {log_q[n0].rw, log_q[n0+1].rw}, 2'b01);
      chk("raw_rd_after_release", log_q[n0+1].cyc > log_q[n0].rel, 1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/io_sched.md
IO_SCHED -- requirements
Module: io_sched

Interface
REQ-001 SHALL: C16M  in  1  sole clock; all state changes on its rising edge.
REQ-002 SHALL: nRES  in  1  reset; synchronous, active-low.
REQ-003 SHALL: CPUREQ  in  1  CPU I/O request level, held until CPUACK seen.
REQ-004 SHALL: CPURW  in  1  1=read, 0=write; valid with CPUREQ.
REQ-005 SHALL: CPULDS, CPUUDS  in  1 each  byte strobes; valid with CPUREQ.
REQ-006 SHALL: CPUA  in  23  word address A[23:1]; CPUD  in  16  write data.
REQ-007 SHALL: CPUACK  out  1  one-cycle pulse; request accepted or completed.
REQ-008 SHALL: CPUQ  out  16  read data, valid from the CPUACK cycle of a read until the next read's CPUACK.
REQ-009 SHALL: IOREQ, IORW, IOLDS, IOUDS  out  1 each  IO bus slave port request.
REQ-010 SHALL: IOA  out  23, IOD  out  16  address/write data for the active IO cycle.
REQ-011 SHALL: IOACT, IODONE  in  1 each  IO bus master activity and termination.
REQ-012 SHALL: IODIN  in  16  read data from the PDS data-in latch.
REQ-013 SHALL: BUSY  out  1  high while any IO cycle is active or buffered.

Function
REQ-014 SHALL: states IDLE, ISSUE, WAIT, RECOV; 2-bit encoding.
REQ-015 SHALL: IDLE->ISSUE only when a source is pending and IOACT=0.
REQ-016 SHALL: ISSUE drives IOREQ=1 with IORW/IOLDS/IOUDS/IOA/IOD from the selected source; ISSUE->WAIT when IOACT=1.
REQ-017 SHALL: WAIT holds IOREQ=1 and all IO outputs stable; on IODONE=1, IOREQ drops next cycle and state->RECOV.
REQ-018 SHALL: RECOV->IDLE when IOACT=0; no new IOREQ before then.
REQ-019 SHALL: read completion captures IODIN into CPUQ in the IODONE cycle; CPUACK pulses the following cycle.
REQ-020 SHALL: a request is new only while internal flag ACKD=0; ACKD set by CPUACK, cleared when CPUREQ=0.
REQ-021 SHALL: source priority: posted-write buffer before CPU direct; reads never bypass buffered writes.
REQ-022 SHALL: IOA/IOD/IORW hold last values when IOREQ=0; IOLDS/IOUDS=0 when IOREQ=0.
REQ-023 SHALL: BUSY = (state!=IDLE) or buffer non-empty or (CPUREQ and not ACKD).

Reset
REQ-024 SHALL: nRES=0 forces state IDLE, IOREQ=0, IOLDS=IOUDS=0, IORW=1, CPUACK=0, ACKD=0, buffer empty, CPUQ=0, IOA=0, IOD=0.
REQ-025 SHALL: reset mid-cycle drops IOREQ next edge; first post-reset issue waits for IOACT=0 (REQ-015).

Configuration
REQ-026 SHALL: macro IOSCHED_WRPOST_EN defined: 2-entry posted-write FIFO (A, D, LDS, UDS per entry), 1-bit wrap pointers plus 2-bit count.
REQ-027 SHALL: with it, a new write is accepted when count<2, CPUACK the next cycle; full is evaluated before same-cycle pop (no push when full even if popping).
REQ-028 SHALL: with it, a new read waits until count=0 and state=IDLE before issuing.
REQ-029 SHALL: macro undefined: no buffer; writes complete like reads (CPUACK after IODONE), CPUQ unchanged on writes.

Structure
REQ-030 SHALL: shared package io_pkg holds state enum, ADDR_W=23, DATA_W=16, WPOST_DEPTH=2.
REQ-031 SHALL: FIFO is sub-module io_wpost_fifo, instantiated only under IOSCHED_WRPOST_EN.

Verification
REQ-032 SHALL: read A=0x7FFFFF, IODONE 5 cycles after IOACT, IODIN=0xA55A -> CPUQ=0xA55A, one CPUACK, IOREQ low next cycle.
REQ-033 SHALL: (EN) three back-to-back writes, IO stalled -> ACK for first two within 1 cycle each, third ACK only after first IODONE; IO order matches CPU order.
REQ-034 SHALL: (EN) write 0x1234@0x100 buffered then read 0x100 -> read IOREQ issued only after write IODONE and IOACT=0.
REQ-035 SHALL: nRES pulsed while in WAIT with IOACT=1 -> IOREQ=0 next edge; pending request reissued only after IOACT=0.
REQ-036 SHALL: CPUREQ held high 10 cycles after CPUACK -> exactly one IO cycle, one CPUACK.
